sr_mc_control: RTL and testbench

Multi-cycle control unit for the schoolRISCV core. It generalises the single-cycle decoder into a registered FSM that sequences FETCH/DECODE/EXEC/MEM/WB. It adds LW/SW support, req/ack memory handshakes, a wait-state timeout, and a parametrised ALU-control width. It sits between the instruction register / ALU datapath and the instruction and data memory ports.

---
 rtl/sr_mc_control.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_sr_mc_control.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_mc_control.sv
// -----------------------------------------------------------------------------
// sr_mc_control
// Multi-cycle control unit for the schoolRISCV core. A registered FSM walks
// each instruction through FETCH / DECODE / EXEC / MEM / WB. It supports LW/SW
// through req/ack handshakes on the instruction and data ports. A wait-state
// counter turns a stalled bus into a sticky bus error.
//
// Optional feature macro: SR_MC_CONTROL_TRAP_EN
//   defined   : an illegal instruction spends one TRAP cycle (trap=1,
//               pcWrite=1, pcSrc=1) before the next fetch.
//   undefined : an illegal instruction is a 2-cycle NOP and trap is tied 0.
//
// Parameters
//   ALU_CTRL_W  : width of aluControl; the 3-bit ALU codes are zero-extended.
//   MEM_TIMEOUT : un-acked request cycles tolerated before ERROR (0 = never).
//
// Ports
//   clk, rst_n               : clock, synchronous active-low reset
//   cmdOp/cmdF3/cmdF7        : opcode, funct3 and funct7 from the IR
//   aluZero                  : ALU result is zero (branch condition)
//   imem_ack / dmem_ack      : fetch / data access complete this cycle
//   imem_req                 : instruction fetch request
//   irWrite, pcWrite, pcSrc  : IR load, PC load, PC source (0 +4, 1 target)
//   regWrite, aluSrc, wdSrc  : RF write, ALU B source, write-data select
//   aluControl               : ALU operation
//   dmem_req, dmem_we        : data request, store qualifier
//   busError                 : sticky timeout flag
//   trap                     : illegal-instruction trap pulse
//   state                    : current FSM state, for debug
//
// Moore controls are flopped from the next state, so they change together
// with the state register. The only combinational terms are the ack-qualified
// fetch strobes and the branch-taken decision on aluZero.
// -----------------------------------------------------------------------------
module sr_mc_control #(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            cmdOp,
    input  logic [2:0]            cmdF3,
    input  logic [6:0]            cmdF7,
    input  logic                  aluZero,
    input  logic                  imem_ack,
    input  logic                  dmem_ack,
    output logic                  imem_req,
    output logic                  irWrite,
    output logic                  pcWrite,
    output logic                  pcSrc,
    output logic                  regWrite,
    output logic                  aluSrc,
    output logic [1:0]            wdSrc,
    output logic [ALU_CTRL_W-1:0] aluControl,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic                  busError,
    output logic                  trap,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    // Instruction class. CLS_NOP doubles as "illegal".
    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_ALU  = 3'd1,
        CLS_ALUI = 3'd2,
        CLS_LUI  = 3'd3,
        CLS_BR   = 3'd4,
        CLS_LW   = 3'd5,
        CLS_SW   = 3'd6
    } cls_t;

    typedef struct packed {
        cls_t                  cls;
        logic [ALU_CTRL_W-1:0] alu;
        logic                  cond_zero;   // 1: BEQ, 0: BNE
    } dec_t;

    // ALU operation codes shared with the schoolRISCV datapath
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(3'b000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(3'b001);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(3'b010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(3'b011);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(3'b100);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(3'b101);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam dec_t DEC_NOP = '{cls: CLS_NOP, alu: ALU_ADD, cond_zero: 1'b0};

    // Wait counter only needs to reach MEM_TIMEOUT.
    localparam int                CNT_W       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
    localparam logic              TIMEOUT_EN  = (MEM_TIMEOUT > 0);

`ifdef SR_MC_CONTROL_TRAP_EN
    localparam state_t ILLEGAL_NEXT = ST_TRAP;
`else
    localparam state_t ILLEGAL_NEXT = ST_FETCH;
`endif

    // Map the IR fields onto an instruction class and ALU operation.
    function automatic dec_t decode_cmd(input logic [6:0] op,
                                        input logic [2:0] f3,
                                        input logic [6:0] f7);
        dec_t d;
        d = DEC_NOP;
        case (op)
            OP_RTYPE: begin
                case ({f7, f3})
                    {F7_BASE, 3'b000}: begin d.cls = CLS_ALU; d.alu = ALU_ADD;  end
                    {F7_ALT,  3'b000}: begin d.cls = CLS_ALU; d.alu = ALU_SUB;  end
                    {F7_BASE, 3'b110}: begin d.cls = CLS_ALU; d.alu = ALU_OR;   end
                    {F7_BASE, 3'b100}: begin d.cls = CLS_ALU; d.alu = ALU_XOR;  end
                    {F7_BASE, 3'b101}: begin d.cls = CLS_ALU; d.alu = ALU_SRL;  end
                    {F7_BASE, 3'b011}: begin d.cls = CLS_ALU; d.alu = ALU_SLTU; end
                    default:           d = DEC_NOP;
                endcase
            end
            OP_ALUI: begin
                if (f3 == 3'b000) d.cls = CLS_ALUI;
                else              d = DEC_NOP;
            end
            OP_LUI: d.cls = CLS_LUI;
            OP_BRANCH: begin
                case (f3)
                    3'b000:  begin d.cls = CLS_BR; d.alu = ALU_SUB; d.cond_zero = 1'b1; end
                    3'b001:  begin d.cls = CLS_BR; d.alu = ALU_SUB; d.cond_zero = 1'b0; end
                    default: d = DEC_NOP;
                endcase
            end
            OP_LOAD: begin
                if (f3 == 3'b010) d.cls = CLS_LW;
                else              d = DEC_NOP;
            end
            OP_STORE: begin
                if (f3 == 3'b010) d.cls = CLS_SW;
                else              d = DEC_NOP;
            end
            default: d = DEC_NOP;
        endcase
        return d;
    endfunction

    state_t                state_r;
    state_t                state_next_s;
    dec_t                  dec_r;
    dec_t                  dec_s;
    dec_t                  dec_next_s;
    logic [CNT_W-1:0]      wait_cnt_r;
    logic                  timeout_s;
    logic                  taken_s;

    logic                  imem_req_r,   imem_req_next_s;
    logic                  dmem_req_r,   dmem_req_next_s;
    logic                  dmem_we_r,    dmem_we_next_s;
    logic                  reg_write_r,  reg_write_next_s;
    logic                  alu_src_r,    alu_src_next_s;
    logic [1:0]            wd_src_r,     wd_src_next_s;
    logic [ALU_CTRL_W-1:0] alu_ctrl_r,   alu_ctrl_next_s;
    logic                  bus_error_r,  bus_error_next_s;
    logic                  trap_r,       trap_next_s;
    logic                  branch_r,     branch_next_s;
    logic                  cond_zero_r,  cond_zero_next_s;

    assign dec_s     = decode_cmd(cmdOp, cmdF3, cmdF7);
    assign timeout_s = TIMEOUT_EN && (wait_cnt_r == TIMEOUT_VAL);

    // Decode that will be in force next cycle; the latch only loads in DECODE
    always_comb begin
        dec_next_s = dec_r;
        if (state_r == ST_DECODE) dec_next_s = dec_s;
        else                      dec_next_s = dec_r;
    end

    // Next-state logic; an ack that coincides with the timeout wins
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack)       state_next_s = ST_DECODE;
                else if (timeout_s) state_next_s = ST_ERROR;
                else                state_next_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (dec_s.cls != CLS_NOP) state_next_s = ST_EXEC;
                else                      state_next_s = ILLEGAL_NEXT;
            end
            ST_EXEC: begin
                if (dec_r.cls == CLS_LW || dec_r.cls == CLS_SW) state_next_s = ST_MEM;
                else                                            state_next_s = ST_FETCH;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (dec_r.cls == CLS_LW) state_next_s = ST_WB;
                    else                     state_next_s = ST_FETCH;
                end else if (timeout_s) begin
                    state_next_s = ST_ERROR;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB:    state_next_s = ST_FETCH;
            ST_TRAP:  state_next_s = ST_FETCH;
            ST_ERROR: state_next_s = ST_ERROR;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Moore control values for the state being entered
    always_comb begin
        imem_req_next_s  = 1'b0;
        dmem_req_next_s  = 1'b0;
        dmem_we_next_s   = 1'b0;
        reg_write_next_s = 1'b0;
        alu_src_next_s   = 1'b0;
        wd_src_next_s    = 2'd0;
        alu_ctrl_next_s  = ALU_ADD;
        bus_error_next_s = 1'b0;
        trap_next_s      = 1'b0;
        branch_next_s    = 1'b0;
        cond_zero_next_s = 1'b0;
        case (state_next_s)
            ST_FETCH: imem_req_next_s = 1'b1;
            ST_EXEC: begin
                case (dec_next_s.cls)
                    CLS_ALU: begin
                        reg_write_next_s = 1'b1;
                        alu_ctrl_next_s  = dec_next_s.alu;
                    end
                    CLS_ALUI: begin
                        reg_write_next_s = 1'b1;
                        alu_src_next_s   = 1'b1;
                    end
                    CLS_LUI: begin
                        reg_write_next_s = 1'b1;
                        wd_src_next_s    = 2'd1;
                    end
                    CLS_BR: begin
                        branch_next_s    = 1'b1;
                        alu_ctrl_next_s  = ALU_SUB;
                        cond_zero_next_s = dec_next_s.cond_zero;
                    end
                    CLS_LW, CLS_SW: alu_src_next_s = 1'b1;
                    default: alu_ctrl_next_s = ALU_ADD;
                endcase
            end
            ST_MEM: begin
                dmem_req_next_s = 1'b1;
                dmem_we_next_s  = (dec_next_s.cls == CLS_SW);
                alu_src_next_s  = 1'b1;
            end
            ST_WB: begin
                reg_write_next_s = 1'b1;
                wd_src_next_s    = 2'd2;
            end
            ST_TRAP:  trap_next_s      = 1'b1;
            ST_ERROR: bus_error_next_s = 1'b1;
            default:  alu_ctrl_next_s  = ALU_ADD;
        endcase
    end

    // FSM state, wait counter, decode latch and registered controls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            dec_r       <= DEC_NOP;
            wait_cnt_r  <= {CNT_W{1'b0}};
            imem_req_r  <= 1'b0;
            dmem_req_r  <= 1'b0;
            dmem_we_r   <= 1'b0;
            reg_write_r <= 1'b0;
            alu_src_r   <= 1'b0;
            wd_src_r    <= 2'd0;
            alu_ctrl_r  <= ALU_ADD;
            bus_error_r <= 1'b0;
            trap_r      <= 1'b0;
            branch_r    <= 1'b0;
            cond_zero_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            dec_r   <= dec_next_s;
            // Any state change (which includes every ack) restarts the count
            if (state_next_s != state_r) begin
                wait_cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == ST_FETCH || state_r == ST_MEM) &&
                         (wait_cnt_r != TIMEOUT_VAL)) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            imem_req_r  <= imem_req_next_s;
            dmem_req_r  <= dmem_req_next_s;
            dmem_we_r   <= dmem_we_next_s;
            reg_write_r <= reg_write_next_s;
            alu_src_r   <= alu_src_next_s;
            wd_src_r    <= wd_src_next_s;
            alu_ctrl_r  <= alu_ctrl_next_s;
            bus_error_r <= bus_error_next_s;
            trap_r      <= trap_next_s;
            branch_r    <= branch_next_s;
            cond_zero_r <= cond_zero_next_s;
        end
    end

    // BEQ takes on zero, BNE on non-zero
    assign taken_s = branch_r & (aluZero == cond_zero_r);

    assign imem_req   = imem_req_r;
    assign irWrite    = imem_req_r & imem_ack;
    assign pcWrite    = (imem_req_r & imem_ack) | taken_s | trap_r;
    assign pcSrc      = taken_s | trap_r;
    assign regWrite   = reg_write_r;
    assign aluSrc     = alu_src_r;
    assign wdSrc      = wd_src_r;
    assign aluControl = alu_ctrl_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_we_r;
    assign busError   = bus_error_r;
    assign state      = state_r;
`ifdef SR_MC_CONTROL_TRAP_EN
    assign trap       = trap_r;
`else
    assign trap       = 1'b0;
`endif

endmodule

// File: tb/tb_sr_mc_control.sv
// -----------------------------------------------------------------------------
// tb_sr_mc_control
// Self-checking bench for sr_mc_control (MEM_TIMEOUT=4). For each instruction,
// the reference model builds the expected per-cycle sequence of states and
// controls. It does this from the instruction class and the chosen ack delays.
// The bench then drives acks and fields cycle by cycle and compares all outputs.
// -----------------------------------------------------------------------------
module tb_sr_mc_control;

    localparam int TO = 4;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4, S_WB    = 3'd5, S_TRAP   = 3'd6, S_ERROR = 3'd7;

    localparam logic [2:0] A_ADD = 3'd0, A_OR = 3'd1, A_SRL = 3'd2, A_SLTU = 3'd3;
    localparam logic [2:0] A_SUB = 3'd4, A_XOR = 3'd5;

    localparam int K_ILL = 0, K_R = 1, K_ADDI = 2, K_LUI = 3, K_BEQ = 4, K_BNE = 5, K_LW = 6, K_SW = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] cmdOp = 7'd0;
    logic [2:0] cmdF3 = 3'd0;
    logic [6:0] cmdF7 = 7'd0;
    logic       aluZero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic       imem_req, irWrite, pcWrite, pcSrc, regWrite, aluSrc;
    logic [1:0] wdSrc;
    logic [2:0] aluControl;
    logic       dmem_req, dmem_we, busError, trap;
    logic [2:0] state;
    logic [17:0] obs;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [17:0] v;
        logic [1:0]  ia;   // imem_ack: 0, 1, or 2 = random
        logic [1:0]  da;   // dmem_ack: 0, 1, or 2 = random
        bit          dec;  // drive the real instruction fields this cycle
    } ent_t;

    ent_t q[$];

    sr_mc_control #(.ALU_CTRL_W(3), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
        .aluZero(aluZero), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
        .regWrite(regWrite), .aluSrc(aluSrc), .wdSrc(wdSrc), .aluControl(aluControl),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .busError(busError), .trap(trap),
        .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, imem_req, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc,
                  aluControl, dmem_req, dmem_we, busError, trap};

    function automatic logic [17:0] mk(input logic [2:0] st, input logic ireq, input logic irw,
                                       input logic pcw, input logic pcs, input logic rw,
                                       input logic asrc, input logic [1:0] wd, input logic [2:0] alu,
                                       input logic dreq, input logic dwe, input logic berr,
                                       input logic tr);
        return {st, ireq, irw, pcw, pcs, rw, asrc, wd, alu, dreq, dwe, berr, tr};
    endfunction

    // Instruction class from the supported-instruction list
    function automatic int kind_of(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        if (op == 7'b0110011 && f7 == 7'b0000000 &&
            (f3 == 3'b000 || f3 == 3'b110 || f3 == 3'b100 || f3 == 3'b101 || f3 == 3'b011)) return K_R;
        if (op == 7'b0110011 && f7 == 7'b0100000 && f3 == 3'b000) return K_R;
        if (op == 7'b0010011 && f3 == 3'b000) return K_ADDI;
        if (op == 7'b0110111) return K_LUI;
        if (op == 7'b1100011 && f3 == 3'b000) return K_BEQ;
        if (op == 7'b1100011 && f3 == 3'b001) return K_BNE;
        if (op == 7'b0000011 && f3 == 3'b010) return K_LW;
        if (op == 7'b0100011 && f3 == 3'b010) return K_SW;
        return K_ILL;
    endfunction

    function automatic logic [2:0] r_alu(input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'b000:  return (f7 == 7'b0100000) ? A_SUB : A_ADD;
            3'b110:  return A_OR;
            3'b100:  return A_XOR;
            3'b101:  return A_SRL;
            3'b011:  return A_SLTU;
            default: return A_ADD;
        endcase
    endfunction

    task automatic push(input logic [17:0] v, input logic [1:0] ia, input logic [1:0] da, input bit dec);
        ent_t e;
        e.v = v; e.ia = ia; e.da = da; e.dec = dec;
        q.push_back(e);
    endtask

    // Run one instruction from FETCH; fw/mw are wait cycles before the ack (> TO = never acked)
    task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int fw, input int mw, input logic z);
        int   k;
        int   n;
        logic tk;
        k = kind_of(op, f3, f7);
        q.delete();
        n = (fw > TO) ? TO + 1 : fw;
        for (int i = 0; i < n; i++) push(mk(S_FETCH,H,L,L,L,L,L,2'd0,A_ADD,L,L,L,L), 2'd0, 2'd2, 1'b0);
        if (fw > TO) begin
            for (int i = 0; i < 4; i++) push(mk(S_ERROR,L,L,L,L,L,L,2'd0,A_ADD,L,L,H,L), 2'd2, 2'd2, 1'b0);
        end else begin
            push(mk(S_FETCH,H,H,H,L,L,L,2'd0,A_ADD,L,L,L,L), 2'd1, 2'd2, 1'b0);
            push(mk(S_DECODE,L,L,L,L,L,L,2'd0,A_ADD,L,L,L,L), 2'd2, 2'd2, 1'b1);
            case (k)
                K_ILL: begin
`ifdef SR_MC_CONTROL_TRAP_EN
                    push(mk(S_TRAP,L,L,H,H,L,L,2'd0,A_ADD,L,L,L,H), 2'd2, 2'd2, 1'b0);
`endif
                end
                K_R:    push(mk(S_EXEC,L,L,L,L,H,L,2'd0,r_alu(f3, f7),L,L,L,L), 2'd2, 2'd2, 1'b0);
                K_ADDI: push(mk(S_EXEC,L,L,L,L,H,H,2'd0,A_ADD,L,L,L,L), 2'd2, 2'd2, 1'b0);
                K_LUI:  push(mk(S_EXEC,L,L,L,L,H,L,2'd1,A_ADD,L,L,L,L), 2'd2, 2'd2, 1'b0);
                K_BEQ, K_BNE: begin
                    tk = (z == (k == K_BEQ));
                    push(mk(S_EXEC,L,L,tk,tk,L,L,2'd0,A_SUB,L,L,L,L), 2'd2, 2'd2, 1'b0);
                end
                default: begin
                    push(mk(S_EXEC,L,L,L,L,L,H,2'd0,A_ADD,L,L,L,L), 2'd2, 2'd2, 1'b0);
                    n = (mw > TO) ? TO + 1 : mw;
                    for (int i = 0; i < n; i++)
                        push(mk(S_MEM,L,L,L,L,L,H,2'd0,A_ADD,H,(k == K_SW),L,L), 2'd2, 2'd0, 1'b0);
                    if (mw > TO) begin
                        for (int i = 0; i < 4; i++)
                            push(mk(S_ERROR,L,L,L,L,L,L,2'd0,A_ADD,L,L,H,L), 2'd2, 2'd2, 1'b0);
                    end else begin
                        push(mk(S_MEM,L,L,L,L,L,H,2'd0,A_ADD,H,(k == K_SW),L,L), 2'd2, 2'd1, 1'b0);
                        if (k == K_LW) push(mk(S_WB,L,L,L,L,H,L,2'd2,A_ADD,L,L,L,L), 2'd2, 2'd2, 1'b0);
                    end
                end
            endcase
        end
        foreach (q[i]) begin
            @(negedge clk);
            if (q[i].dec) begin
                cmdOp = op; cmdF3 = f3; cmdF7 = f7;
            end else begin
                cmdOp = 7'($urandom); cmdF3 = 3'($urandom); cmdF7 = 7'($urandom);
            end
            imem_ack = (q[i].ia == 2'd2) ? 1'($urandom) : q[i].ia[0];
            dmem_ack = (q[i].da == 2'd2) ? 1'($urandom) : q[i].da[0];
            aluZero  = (q[i].v[17:15] == S_EXEC) ? z : 1'($urandom);
            #1;
            n_checks++;
            if (obs !== q[i].v)
                $display("FAIL %s cycle %0d: got %h expected %h", nm, i, obs, q[i].v);
            else
                n_pass++;
        end
    endtask

    // Reset without checks; leaves the DUT in FETCH just after a rising edge
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            imem_ack = 1'($urandom); dmem_ack = 1'($urandom); aluZero = 1'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (obs !== 18'h0) $display("FAIL reset_hold%0d: got %h expected %h", i, obs, 18'h0);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        n_checks++;
        if (obs !== 18'h0) $display("FAIL reset_release: got %h expected %h", obs, 18'h0);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== mk(S_FETCH,H,L,L,L,L,L,2'd0,A_ADD,L,L,L,L))
            $display("FAIL first_fetch: got %h expected %h", obs, mk(S_FETCH,H,L,L,L,L,L,2'd0,A_ADD,L,L,L,L));
        else n_pass++;
    endtask

    task automatic test_alu();
        run_instr("add",  7'b0110011, 3'b000, 7'b0000000, 0, 0, 1'b0);
        run_instr("sub",  7'b0110011, 3'b000, 7'b0100000, 0, 0, 1'b0);
        run_instr("or",   7'b0110011, 3'b110, 7'b0000000, 1, 0, 1'b0);
        run_instr("xor",  7'b0110011, 3'b100, 7'b0000000, 0, 0, 1'b1);
        run_instr("srl",  7'b0110011, 3'b101, 7'b0000000, 2, 0, 1'b0);
        run_instr("sltu", 7'b0110011, 3'b011, 7'b0000000, 0, 0, 1'b0);
        run_instr("addi", 7'b0010011, 3'b000, 7'b1010101, 0, 0, 1'b0);
        run_instr("lui",  7'b0110111, 3'b111, 7'b1111111, 0, 0, 1'b0);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", 7'b1100011, 3'b000, 7'b0000000, 0, 0, 1'b1);
        run_instr("beq_z0", 7'b1100011, 3'b000, 7'b0000000, 0, 0, 1'b0);
        run_instr("bne_z1", 7'b1100011, 3'b001, 7'b0000000, 0, 0, 1'b1);
        run_instr("bne_z0", 7'b1100011, 3'b001, 7'b0000000, 0, 0, 1'b0);
    endtask

    task automatic test_lw_sw();
        run_instr("lw_wait3", 7'b0000011, 3'b010, 7'b0000000, 0, 3, 1'b0);
        run_instr("sw_wait0", 7'b0100011, 3'b010, 7'b0000000, 0, 0, 1'b0);
        run_instr("lw_wait0", 7'b0000011, 3'b010, 7'b0000000, 0, 0, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr("ill_op",  7'b1111111, 3'b000, 7'b0000000, 0, 0, 1'b0);
        run_instr("ill_f7",  7'b0110011, 3'b000, 7'b0000001, 0, 0, 1'b0);
        run_instr("ill_lw3", 7'b0000011, 3'b000, 7'b0000000, 0, 0, 1'b0);
        run_instr("ill_br",  7'b1100011, 3'b010, 7'b0000000, 0, 0, 1'b0);
    endtask

    // Ack arriving on the very cycle the counter hits the limit must win
    task automatic test_ack_boundary();
        run_instr("fetch_ack_at_limit", 7'b0000011, 3'b010, 7'b0000000, TO, TO, 1'b0);
        run_instr("sw_ack_at_limit",    7'b0100011, 3'b010, 7'b0000000, TO, TO, 1'b0);
    endtask

    task automatic test_timeout();
        apply_reset();
        run_instr("fetch_timeout", 7'b0110011, 3'b000, 7'b0000000, 99, 0, 1'b0);
        apply_reset();
        run_instr("mem_timeout", 7'b0000011, 3'b010, 7'b0000000, 0, 99, 1'b0);
        apply_reset();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        cmdOp = 7'b0000011; cmdF3 = 3'b010; cmdF7 = 7'b0000000; imem_ack = 1'b1; dmem_ack = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({state, dmem_req} !== {S_MEM, H})
            $display("FAIL mid_mem: got %h expected %h", {state, dmem_req}, {S_MEM, H});
        else n_pass++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== 18'h0) $display("FAIL mid_reset_drop: got %h expected %h", obs, 18'h0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_random();
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         sel;
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 14);
            f7 = 7'($urandom);
            f3 = 3'($urandom);
            case (sel)
                0:  begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000000; end
                1:  begin op = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
                2:  begin op = 7'b0110011; f3 = 3'b110; f7 = 7'b0000000; end
                3:  begin op = 7'b0110011; f3 = 3'b100; f7 = 7'b0000000; end
                4:  begin op = 7'b0110011; f3 = 3'b101; f7 = 7'b0000000; end
                5:  begin op = 7'b0110011; f3 = 3'b011; f7 = 7'b0000000; end
                6:  begin op = 7'b0010011; f3 = 3'b000; end
                7:  begin op = 7'b0110111; end
                8:  begin op = 7'b1100011; f3 = 3'b000; end
                9:  begin op = 7'b1100011; f3 = 3'b001; end
                10: begin op = 7'b0000011; f3 = 3'b010; end
                11: begin op = 7'b0100011; f3 = 3'b010; end
                12: begin op = 7'b0110011; end
                default: op = 7'($urandom);
            endcase
            run_instr("random", op, f3, f7, $urandom_range(0, TO), $urandom_range(0, TO), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_lw_sw();
        test_illegal();
        test_ack_boundary();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
